// File: rtl/flash_boot_dma.sv
// flash_boot_dma: boot-time loader that streams LEN bytes from the SPI flash
// reader into RAM and holds the CPU in reset until the image is in place.
//
// Bytes are packed little-endian into BPW-byte words. Each finished word goes
// into a small FIFO. The FIFO drains through a valid/ready RAM write port.
// The first cycle after reset release acts as an implicit start.
//
// Optional feature (macro FLASH_BOOT_DMA_CHECKSUM_EN): a 32-bit wrapping byte
// checksum is compared with expected_sum at completion. On a mismatch sum_err
// is raised and done stays low.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  one-cycle load request (honoured in IDLE/DONE/ERROR)
//   ram_busy               RAM still initialising; load waits while high
//   flash_start/addr       kick pulse and constant source address to spiflash
//   flash_dout/strb        incoming byte stream (no backpressure)
//   mem_valid/ready/addr/wdata/wstrb   RAM write handshake
//   busy, done, overflow   load status
//   bytes_seen             bytes accepted in the current load
//   checksum, expected_sum, sum_err    only with FLASH_BOOT_DMA_CHECKSUM_EN
module flash_boot_dma #(
    parameter logic [23:0] SRC_ADDR   = 24'h50_0000,
    parameter int unsigned DST_ADDR   = 0,
    parameter int unsigned LEN        = 262144,
    parameter int unsigned BPW        = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 23
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                ram_busy,
    output logic                flash_start,
    output logic [23:0]         flash_addr,
    input  logic [7:0]          flash_dout,
    input  logic                flash_strb,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [8*BPW-1:0]    mem_wdata,
    output logic [BPW-1:0]      mem_wstrb,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [31:0]         bytes_seen
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
    ,
    input  logic [31:0]         expected_sum,
    output logic [31:0]         checksum,
    output logic                sum_err
`endif
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LaneW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned DataW = 8 * BPW;

    typedef enum logic [2:0] {
        StIdle, StWaitRam, StKick, StStream, StDrain, StDone, StError
    } state_e;

    state_e               state_q, state_d;
    logic                 first_q;
    logic                 load_clr;
    logic [31:0]          bytes_q;
    logic [DataW-1:0]     pack_q;
    logic [DataW-1:0]     stage_q;
    logic [BPW-1:0]       stage_strb_q;
    logic                 stage_vld_q;
    logic [DataW-1:0]     fifo_data [FIFO_DEPTH];
    logic [BPW-1:0]       fifo_strb [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 done_q, ovf_q;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
    logic [31:0]          sum_q;
    logic                 sum_err_q;
`endif

    logic [LaneW-1:0]     lane;
    logic                 accept, last_byte, word_end;
    logic [DataW-1:0]     word_next;
    logic [BPW-1:0]       strb_next;
    logic                 active, fifo_empty, fifo_full;
    logic                 pop, push_req, push, ovf_evt;

    assign lane       = LaneW'(bytes_q % BPW);
    assign accept     = (state_q == StStream) && flash_strb && (bytes_q < LEN);
    assign last_byte  = (bytes_q == 32'(LEN - 1));
    assign word_end   = (lane == LaneW'(BPW - 1)) || last_byte;

    assign active     = (state_q == StStream) || (state_q == StDrain);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign pop        = mem_valid && mem_ready;
    assign push_req   = stage_vld_q && active;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_evt    = push_req && fifo_full && !pop;

    // Merge the incoming byte into the pack register; lanes fill from 0 upward,
    // so the valid mask of the word in progress is lanes 0..lane.
    always_comb begin
        word_next = pack_q;
        strb_next = '0;
        for (int i = 0; i < BPW; i++) begin
            if (LaneW'(i) == lane) word_next[8*i +: 8] = flash_dout;
            if (LaneW'(i) <= lane) strb_next[i] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start || first_q) begin
                    state_d  = StWaitRam;
                    load_clr = 1'b1;
                end
            end
            StWaitRam: if (!ram_busy) state_d = StKick;
            StKick:    state_d = StStream;
            StStream:  if (accept && last_byte) state_d = StDrain;
            StDrain:   if (!stage_vld_q && fifo_empty) state_d = StDone;
            StDone, StError: begin
                if (start) begin
                    state_d  = StWaitRam;
                    load_clr = 1'b1;
                end
            end
            default:   state_d = StIdle;
        endcase
        if (ovf_evt) state_d = StError;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            first_q      <= 1'b1;
            bytes_q      <= '0;
            pack_q       <= '0;
            stage_q      <= '0;
            stage_strb_q <= '0;
            stage_vld_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= ADDR_W'(DST_ADDR);
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
            sum_q        <= '0;
            sum_err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
            if (load_clr) begin
                bytes_q      <= '0;
                pack_q       <= '0;
                stage_q      <= '0;
                stage_strb_q <= '0;
                stage_vld_q  <= 1'b0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
                addr_q       <= ADDR_W'(DST_ADDR);
                done_q       <= 1'b0;
                ovf_q        <= 1'b0;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
                sum_q        <= '0;
                sum_err_q    <= 1'b0;
`endif
            end else begin
                stage_vld_q <= 1'b0;
                if (accept) begin
                    bytes_q <= bytes_q + 32'd1;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
                    sum_q   <= sum_q + 32'(flash_dout);
`endif
                    if (word_end) begin
                        // Finished word waits one cycle in the stage before the FIFO.
                        stage_q      <= word_next;
                        stage_strb_q <= strb_next;
                        stage_vld_q  <= 1'b1;
                        pack_q       <= '0;
                    end else begin
                        pack_q <= word_next;
                    end
                end
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                    addr_q   <= addr_q + ADDR_W'(BPW);
                end
                if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
                else if (!push && pop) count_q <= count_q - (PtrW + 1)'(1);
                if (ovf_evt) ovf_q <= 1'b1;
                if (state_q == StDone) begin
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
                    done_q    <= (sum_q == expected_sum);
                    sum_err_q <= (sum_q != expected_sum);
`else
                    done_q    <= 1'b1;
`endif
                end
            end
        end
    end

    // Storage needs no reset: contents are only visible through mem_valid.
    always_ff @(posedge clk) begin
        if (push && !load_clr) begin
            fifo_data[wr_ptr_q] <= stage_q;
            fifo_strb[wr_ptr_q] <= stage_strb_q;
        end
    end

    assign mem_valid   = active && !fifo_empty;
    assign mem_addr    = mem_valid ? addr_q : '0;
    assign mem_wdata   = mem_valid ? fifo_data[rd_ptr_q] : '0;
    assign mem_wstrb   = mem_valid ? fifo_strb[rd_ptr_q] : '0;
    assign flash_start = (state_q == StKick);
    assign flash_addr  = SRC_ADDR;
    assign busy        = (state_q == StWaitRam) || (state_q == StKick) ||
                         (state_q == StStream)  || (state_q == StDrain);
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign bytes_seen  = bytes_q;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
    assign checksum    = sum_q;
    assign sum_err     = sum_err_q;
`endif

endmodule

// File: tb/tb_flash_boot_dma.sv
// Randomised bench for flash_boot_dma. The expected RAM writes of each load
// are computed up front from the image bytes (address, packed data, lane mask
// per word). A single negedge process compares every RAM write and bytes_seen
// against them.
module tb_flash_boot_dma;

    localparam logic [23:0] SRC   = 24'h5A_1234;
    localparam int unsigned DST   = 48;
    localparam int unsigned LEN   = 21;
    localparam int unsigned BPW   = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 6;
    localparam int unsigned NW    = (LEN + BPW - 1) / BPW;

    logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, ram_busy = 1'b0;
    logic          flash_strb = 1'b0, mem_ready = 1'b0;
    logic [7:0]    flash_dout = 8'h00;
    logic          flash_start, mem_valid, busy, done, overflow;
    logic [23:0]   flash_addr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, bytes_seen;
    logic [3:0]    mem_wstrb;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
    logic [31:0]   expected_sum = 32'h0;
    logic [31:0]   checksum;
    logic          sum_err;
`endif

    flash_boot_dma #(
        .SRC_ADDR(SRC), .DST_ADDR(DST), .LEN(LEN), .BPW(BPW),
        .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .ram_busy(ram_busy),
        .flash_start(flash_start), .flash_addr(flash_addr),
        .flash_dout(flash_dout), .flash_strb(flash_strb),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .busy(busy), .done(done), .overflow(overflow), .bytes_seen(bytes_seen)
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        , .expected_sum(expected_sum), .checksum(checksum), .sum_err(sum_err)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: image bytes and the word writes they must produce.
    logic [7:0]    img    [LEN];
    logic [AW-1:0] e_addr [NW];
    logic [31:0]   e_data [NW];
    logic [3:0]    e_strb [NW];
    logic [31:0]   e_sum;
    int            load_id = 0;

    task automatic build_model(input bit literal);
        e_sum = 0;
        for (int i = 0; i < LEN; i++) begin
            img[i] = literal ? 8'(i + 1) : 8'($urandom);
            e_sum  = e_sum + 32'(img[i]);
        end
        for (int k = 0; k < NW; k++) begin
            e_addr[k] = AW'((DST + k * BPW) % (1 << AW));
            e_data[k] = 32'h0;
            e_strb[k] = 4'h0;
            for (int j = 0; j < BPW; j++) begin
                if (k * BPW + j < LEN) begin
                    e_data[k][8*j +: 8] = img[k * BPW + j];
                    e_strb[k][j]        = 1'b1;
                end
            end
        end
        load_id++;
    endtask

    // Compare process: tracks writes accepted and bytes strobed in this load.
    bit trk = 1'b0;
    int widx = 0, acc = 0, fs_cnt = 0, seen_id = 0;

    always @(negedge clk) begin
        if (seen_id != load_id) begin
            seen_id = load_id;
            widx = 0;
            acc = 0;
            fs_cnt = 0;
        end
        if (resetn && trk) begin
            if (mem_valid) begin
                if (widx < NW) begin
                    check("wr_addr", 64'(mem_addr), 64'(e_addr[widx]));
                    check("wr_data", 64'(mem_wdata), 64'(e_data[widx]));
                    check("wr_strb", 64'(mem_wstrb), 64'(e_strb[widx]));
                end else begin
                    check("extra_write", 64'(mem_valid), 64'd0);
                end
                if (mem_ready) widx++;
            end
            check("bytes_seen", 64'(bytes_seen), 64'((acc < LEN) ? acc : LEN));
            if (widx < NW) check("early_done", 64'(done), 64'd0);
            if (flash_strb) acc++;
            if (flash_start) fs_cnt++;
        end
    end

    // RAM responder: random 0..2 cycle stall before each acceptance pulse.
    bit rdy_en = 1'b1;
    int stall = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_en && mem_valid) begin
            if (stall == 0) begin
                mem_ready = 1'b1;
                stall = $urandom_range(0, 2);
            end else begin
                stall--;
                mem_ready = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    task automatic send_bytes(input int n, input bit gaps);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!flash_start && t < 400);
        check("flash_start_seen", 64'(flash_start), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            flash_dout = (i < LEN) ? img[i] : 8'($urandom);
            flash_strb = 1'b1;
            @(posedge clk);
            #1;
            flash_strb = 1'b0;
        end
        flash_dout = 8'h00;
    endtask

    task automatic wait_end(input bit expect_ok);
        int t = 0;
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        while (!done && !sum_err && t < 300) begin
`else
        while (!done && t < 300) begin
`endif
            @(negedge clk);
            t++;
        end
        check("done", 64'(done), 64'(expect_ok));
        check("busy_at_end", 64'(busy), 64'd0);
        check("writes_total", 64'(widx), 64'(NW));
        check("bytes_total", 64'(bytes_seen), 64'(LEN));
        check("overflow_clear", 64'(overflow), 64'd0);
        check("flash_start_pulses", 64'(fs_cnt), 64'd1);
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(e_sum));
        check("sum_err", 64'(sum_err), 64'(!expect_ok));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit bad_sum);
        trk = 1'b0;
        build_model(1'b0);
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        expected_sum = bad_sum ? e_sum + 32'd1 : e_sum;
`else
        if (bad_sum) check("bad_sum_unsupported", 64'(bad_sum), 64'd0);
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        trk = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flash_start"}, 64'(flash_start), 64'd0);
        check({tag, "_flash_addr"}, 64'(flash_addr), 64'(SRC));
        check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_bytes_seen"}, 64'(bytes_seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Literal image 01..15h; pin the model with hand-computed words.
        build_model(1'b1);
        check("model_w0_addr", 64'(e_addr[0]), 64'd48);
        check("model_w0_data", 64'(e_data[0]), 64'h04030201);
        check("model_w4_addr", 64'(e_addr[4]), 64'd0);
        check("model_w5_data", 64'(e_data[5]), 64'h00000015);
        check("model_w5_strb", 64'(e_strb[5]), 64'h1);
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        expected_sum = e_sum;
`endif

        // Reset values, then auto-start with RAM still busy for 100 cycles.
        ram_busy = 1'b1;
        #23;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        trk = 1'b1;
        @(posedge clk);
        repeat (100) begin
            @(negedge clk);
            check("busy_wait_ram", 64'(busy), 64'd1);
            check("no_kick_while_busy", 64'(flash_start), 64'd0);
        end
        @(posedge clk);
        #1;
        ram_busy = 1'b0;
        send_bytes(LEN, 1'b1);
        wait_end(1'b1);

        // Random images, with stray bytes after the end of the image.
        repeat (3) begin
            do_start(1'b0);
            send_bytes(LEN + $urandom_range(0, 3), 1'b1);
            wait_end(1'b1);
        end

        // RAM never accepts: the FIFO must overrun and the load abort.
        rdy_en = 1'b0;
        do_start(1'b0);
        trk = 1'b0;
        send_bytes(16, 1'b0);
        repeat (4) @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_mem_valid", 64'(mem_valid), 64'd0);
        check("ovf_busy", 64'(busy), 64'd0);
        check("ovf_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rdy_en = 1'b1;
        do_start(1'b0);
        send_bytes(LEN, 1'b1);
        wait_end(1'b1);

`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        do_start(1'b1);
        send_bytes(LEN, 1'b1);
        wait_end(1'b0);
`endif

        // Reset in the middle of a load after six bytes.
        do_start(1'b0);
        send_bytes(6, 1'b0);
        trk = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        build_model(1'b0);
`ifdef FLASH_BOOT_DMA_CHECKSUM_EN
        expected_sum = e_sum;
`endif
        ram_busy = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        trk = 1'b1;
        @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            check("post_reset_no_write", 64'(mem_valid), 64'd0);
            check("post_reset_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        ram_busy = 1'b0;
        send_bytes(LEN, 1'b1);
        wait_end(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/flash_boot_dma.md
Name: flash_boot_dma

Overview:
Parametrised successor to the iosys firmware loader. It streams LEN bytes from the SPI flash reader into RAM, starting at flash address SRC_ADDR and RAM address DST_ADDR. Bytes are packed little-endian into BPW-byte words and written through a valid/ready RAM handshake, buffered by a small FIFO. It sits between the spiflash instance and the RV memory mux and holds the softcore in reset until the load completes.

Parameters:
SRC_ADDR, 24'h50_0000, flash byte address of the image (driven on flash_addr)
DST_ADDR, 0, RAM byte address of the first word; must be a multiple of BPW
LEN, 262144, image length in bytes, >=1; need not be a multiple of BPW
BPW, 4, bytes per RAM word (1, 2 or 4)
FIFO_DEPTH, 4, packed-word FIFO entries, power of two, >=2
ADDR_W, 23, RAM address width

Ports:
clk  in  1  system clock (NES mclk)
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a load (ignored unless IDLE, DONE or ERROR)
ram_busy  in  1  SDRAM still initialising; load waits while high
flash_start  out  1  one-cycle pulse to spiflash
flash_addr  out  24  constant SRC_ADDR
flash_dout  in  8  flash byte
flash_strb  in  1  flash byte valid (no backpressure possible)
mem_valid  out  1  RAM write request
mem_ready  in  1  one-cycle acceptance pulse
mem_addr  out  ADDR_W  word-aligned RAM byte address
mem_wdata  out  8*BPW  packed data
mem_wstrb  out  BPW  byte lanes written
busy  out  1  load in progress
done  out  1  load completed successfully (release CPU reset)
overflow  out  1  FIFO overrun; load aborted
bytes_seen  out  32  bytes received from flash in this load

Behaviour:
- Reset (async): state IDLE; all outputs 0 except flash_addr=SRC_ADDR; FIFO emptied; counters 0. Reset mid-load abandons the load; no further RAM writes occur.
- States: IDLE -> (start) WAIT_RAM -> (!ram_busy) KICK -> STREAM -> DRAIN -> DONE. Any FIFO overrun -> ERROR.
- Auto-start: the first cycle after reset release behaves as if start=1.
- WAIT_RAM: stay while ram_busy=1.
- KICK: flash_start=1 for exactly one cycle, then enter STREAM.
- STREAM: each flash_strb places flash_dout in lane (bytes_seen mod BPW) of the pack register and increments bytes_seen.
  - When the lane reaches BPW-1, or the byte is byte LEN-1, the packed word and its lane mask are pushed into the FIFO on the following cycle. mem_wstrb for a final partial word covers only the received lanes, e.g. LEN=5, BPW=4 -> last wstrb=4'b0001.
  - Unreceived lanes of a partial word are 0.
  - Bytes arriving after LEN are ignored.
- Push into a full FIFO sets overflow=1, enters ERROR, and drops the word. ERROR holds until reset or start; mem_valid=0 in ERROR.
- RAM side: mem_valid=1 whenever FIFO is non-empty and state is STREAM or DRAIN; mem_addr/wdata/wstrb come from the FIFO head and stay stable until mem_ready.
  - On mem_ready: pop the FIFO; word address += BPW.
  - Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- DRAIN is entered after byte LEN-1 is packed. DONE is entered when the FIFO is empty and the last mem_ready has been received. done=1 one cycle later and is held; busy=0.
- busy=1 in WAIT_RAM, KICK, STREAM and DRAIN.
- start in DONE or ERROR clears done, overflow and counters, then re-enters WAIT_RAM. start in any other state is ignored.
- Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
FLASH_BOOT_DMA_CHECKSUM_EN: adds output checksum[31:0] and input expected_sum[31:0].
- checksum = 32-bit wrapping sum of all LEN accepted bytes; cleared on load start.
- On DONE, if checksum != expected_sum, assert output sum_err=1 and keep done=0.
- Without the macro, these ports and the logic are absent, and done asserts unconditionally at completion.

Test Plan:
- ram_busy high 100 cycles after reset -> flash_start pulses once, only after ram_busy falls; busy=1 from first cycle.
- LEN=8, BPW=4, bytes 01..08, mem_ready immediate -> writes addr 0 data 32'h04030201 wstrb 4'hF, addr 4 data 32'h08070605; done=1.
- LEN=5, BPW=4, DST_ADDR=16 -> second write addr 20 data 32'h00000005 wstrb 4'b0001.
- FIFO_DEPTH=2, mem_ready held 0 while 16 bytes stream -> overflow=1, state ERROR, mem_valid=0; start then clean reload gives done=1.
- resetn low mid-stream after 6 bytes -> outputs return to reset values asynchronously; no mem_valid until the next load.
- Checksum build, bytes 0xFF x4, expected_sum=0x3FC -> done=1, sum_err=0; expected 0x3FD -> sum_err=1, done=0.
